// File: rtl/inst_loader_mem.sv
// Instruction memory with a UART program-load path: a big-endian word count header
// followed by that many big-endian words, written from address 0. Registered read port.
module inst_loader_mem #(
  parameter int ADDR_W = 17,
  parameter int DEPTH  = 131072
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              busy,
  output logic              load_done,
  output logic              overflow,
  output logic [ADDR_W:0]   words_loaded,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [31:0]       inst_data
);

  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);
  localparam logic [32:0]     DEPTH_W = 33'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [1:0]  byte_cnt;
  logic [23:0] shift;
  logic [31:0] n_words;
  logic [31:0] consumed;
  logic [31:0] word;
  logic        word_done;
  logic        wr_en;
  logic [31:0] mem [DEPTH];

  // consumed counts every data word received, words_loaded only those that fit
  assign word      = {shift, rx_data};
  assign word_done = rx_valid && (byte_cnt == 2'd3);
  assign wr_en     = (state == DATA) && word_done && (words_loaded < DEPTH_A);

  // Next-state decode
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: begin
        if (load_start) state_n = HDR;
        else            state_n = state;
      end
      HDR: begin
        if (word_done) state_n = (word == 32'd0) ? DONE : DATA;
        else           state_n = HDR;
      end
      DATA: begin
        if (word_done && ((consumed + 32'd1) == n_words)) state_n = DONE;
        else                                               state_n = DATA;
      end
      default: state_n = IDLE;
    endcase
  end

  // Control registers and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      byte_cnt     <= 2'd0;
      shift        <= 24'd0;
      n_words      <= 32'd0;
      consumed     <= 32'd0;
      words_loaded <= '0;
      overflow     <= 1'b0;
      busy         <= 1'b0;
      load_done    <= 1'b0;
    end else begin
      state     <= state_n;
      busy      <= (state_n == HDR) || (state_n == DATA);
      load_done <= (state_n == DONE);
      case (state)
        IDLE, DONE: begin
          if (load_start) begin
            byte_cnt     <= 2'd0;
            consumed     <= 32'd0;
            words_loaded <= '0;
            overflow     <= 1'b0;
          end
        end
        HDR: begin
          if (rx_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            shift    <= {shift[15:0], rx_data};
          end
          if (word_done) begin
            n_words  <= word;
            overflow <= ({1'b0, word} > DEPTH_W);
          end
        end
        DATA: begin
          if (rx_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            shift    <= {shift[15:0], rx_data};
          end
          if (word_done) begin
            consumed <= consumed + 32'd1;
            if (words_loaded < DEPTH_A) words_loaded <= words_loaded + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[words_loaded[MEM_AW-1:0]] <= word;
  end

  // Read port: zero (a NOP) while loading or outside the implemented range
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_data <= 32'd0;
    end else if (busy || ({1'b0, inst_addr} >= DEPTH_A)) begin
      inst_data <= 32'd0;
    end else begin
      inst_data <= mem[inst_addr[MEM_AW-1:0]];
    end
  end

endmodule

// File: tb/tb_inst_loader_mem.sv
// Scoreboard bench for inst_loader_mem: randomized loads checked against an array
// model of the instruction memory and the load status rules.
module tb_inst_loader_mem;
  localparam int AW  = 4;
  localparam int DEP = 8;

  logic          clk = 1'b0;
  logic          rst, load_start, rx_valid;
  logic [7:0]    rx_data;
  logic          busy, load_done, overflow;
  logic [AW:0]   words_loaded;
  logic [AW-1:0] inst_addr;
  logic [31:0]   inst_data;

  inst_loader_mem #(.ADDR_W(AW), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .rx_valid(rx_valid),
    .rx_data(rx_data), .busy(busy), .load_done(load_done), .overflow(overflow),
    .words_loaded(words_loaded), .inst_addr(inst_addr), .inst_data(inst_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_mem [DEP];
  bit          model_ok  [DEP];

  // Monitor: everything queued at a falling edge is due just after the next rising edge
  always @(posedge clk) begin
    #1;
    while (sb.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      string       nm;
      e = sb.pop_front();
      case (e.kind)
        0:       begin act = inst_data;            nm = "inst_data";    end
        1:       begin act = 32'(busy);            nm = "busy";         end
        2:       begin act = 32'(load_done);       nm = "load_done";    end
        3:       begin act = 32'(overflow);        nm = "overflow";     end
        default: begin act = 32'(words_loaded);    nm = "words_loaded"; end
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s actual %h expected %h at %0t", nm, act, e.exp, $time);
      end
    end
  end

  task automatic expect_val(input int k, input logic [31:0] v);
    exp_t e;
    e.kind = k;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic expect_status(input logic b, input logic d, input logic o, input int wl);
    expect_val(1, 32'(b));
    expect_val(2, 32'(d));
    expect_val(3, 32'(o));
    expect_val(4, 32'(wl));
  endtask

  // Called at a falling edge while no load is running
  task automatic read_chk(input int a);
    inst_addr = 4'(a);
    if (a >= DEP)        expect_val(0, 32'd0);
    else if (model_ok[a]) expect_val(0, model_mem[a]);
  endtask

  task automatic busy_read();
    inst_addr = 4'($urandom_range(0, 15));
    expect_val(0, 32'd0);
  endtask

  task automatic readback_all();
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      read_chk(a);
    end
  endtask

  // Called at a falling edge; synchronous reset takes effect on the next rising edge
  task automatic do_reset();
    rst        = 1'b1;
    rx_valid   = 1'b0;
    load_start = 1'b0;
    expect_status(1'b0, 1'b0, 1'b0, 0);
    expect_val(0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] n_hdr, input logic [31:0] words[$],
                         input int max_gap, input bit spur, input int abort_at);
    logic [7:0] bytes[$];
    int         n_wr;
    bytes = {n_hdr[31:24], n_hdr[23:16], n_hdr[15:8], n_hdr[7:0]};
    foreach (words[k]) begin
      bytes.push_back(words[k][31:24]);
      bytes.push_back(words[k][23:16]);
      bytes.push_back(words[k][15:8]);
      bytes.push_back(words[k][7:0]);
    end
    @(negedge clk);
    load_start = 1'b1;
    rx_valid   = 1'b0;
    @(negedge clk);
    load_start = 1'b0;
    for (int i = 0; i < bytes.size(); i++) begin
      int g;
      if (i == abort_at) break;
      g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      repeat (g) begin
        rx_valid   = 1'b0;
        rx_data    = 8'($urandom);
        load_start = spur && ($urandom_range(0, 2) == 0);
        busy_read();
        @(negedge clk);
      end
      rx_valid   = 1'b1;
      rx_data    = bytes[i];
      load_start = spur && ($urandom_range(0, 2) == 0);
      busy_read();
      if (i == 1) expect_status(1'b1, 1'b0, 1'b0, 0);
      if (i == 5) begin
        expect_val(1, 32'd1);
        expect_val(3, 32'(n_hdr > 32'(DEP)));
      end
      @(negedge clk);
    end
    rx_valid   = 1'b0;
    load_start = 1'b0;
    if (abort_at >= 0) begin
      n_wr = (abort_at > 4) ? (abort_at - 4) / 4 : 0;
    end else begin
      n_wr = (n_hdr > 32'(DEP)) ? DEP : int'(n_hdr);
      expect_status(1'b0, 1'b1, n_hdr > 32'(DEP), n_wr);
    end
    for (int k = 0; k < n_wr && k < DEP; k++) begin
      model_mem[k] = words[k];
      model_ok[k]  = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] none[$];
    logic [31:0] w[$];
    rst        = 1'b1;
    load_start = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = 8'd0;
    inst_addr  = '0;
    for (int k = 0; k < DEP; k++) model_ok[k] = 1'b0;

    @(negedge clk);
    do_reset();

    // bytes in IDLE must not leak into the next header
    repeat (3) begin
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b0;

    w = {32'hDEADBEEF};
    do_load(32'd1, w, 0, 1'b0, -1);
    readback_all();

    w = {32'h3C010010, 32'h0000000C};
    do_load(32'd2, w, 0, 1'b0, -1);
    readback_all();

    do_load(32'd0, none, 0, 1'b0, -1);
    readback_all();

    w.delete();
    for (int k = 0; k < 10; k++) w.push_back($urandom);
    do_load(32'd10, w, 0, 1'b0, -1);
    readback_all();

    // bytes in DONE are discarded
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    expect_status(1'b0, 1'b1, 1'b1, DEP);
    readback_all();

    w.delete();
    for (int k = 0; k < 5; k++) w.push_back($urandom);
    do_load(32'd5, w, 0, 1'b0, -1);
    readback_all();
    do_load(32'd5, w, 5, 1'b1, -1);
    readback_all();

    w.delete();
    for (int k = 0; k < 3; k++) w.push_back($urandom);
    do_load(32'd3, w, 0, 1'b0, 10);
    do_reset();
    readback_all();

    w.delete();
    for (int k = 0; k < 4; k++) w.push_back($urandom);
    do_load(32'd4, w, 2, 1'b1, -1);
    readback_all();

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_loader_mem.md
Name: inst_loader_mem

Overview:
- Instruction-memory responder at the far end of the fetch unit's instruction port.
- The fetch unit drives a 17-bit word address; this block returns the 32-bit instruction word one cycle later.
- Also owns the program-load path: it consumes a byte stream from the UART receiver, assembles big-endian words and writes them to consecutive addresses from 0.
- Sits between the UART receiver and the fetch stage in the core top level.

Parameters:
ADDR_W, 17, word-address width; must match the fetch unit's inst_addr width
DEPTH, 131072, number of 32-bit words implemented (≤ 2^ADDR_W); smaller values are for simulation

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
load_start  input  1  one-cycle pulse; begins a program load
rx_valid  input  1  rx_data holds a valid byte this cycle (no backpressure)
rx_data  input  8  received byte
busy  output  1  high while a load is in progress (HDR or DATA)
load_done  output  1  high from load completion until next load_start or reset
overflow  output  1  sticky; header word count exceeded DEPTH
words_loaded  output  ADDR_W+1  number of words written in the current/last load
inst_addr  input  ADDR_W  fetch word address
inst_data  output  32  instruction word, registered

Behaviour:
- Reset values: busy=0, load_done=0, overflow=0, words_loaded=0, inst_data=0, state=IDLE, byte counter=0. Memory contents are not cleared by reset.
- States:
  - IDLE: wait for load_start.
  - HDR: collect 4 bytes forming word count N, big-endian (first byte → bits 31:24).
  - DATA: collect N words, 4 bytes each, big-endian.
  - DONE: load_done=1.
- Transitions:
  - IDLE/DONE + load_start → HDR. Clear words_loaded, overflow, load_done and the byte counter.
  - HDR, 4th byte accepted → DATA if N≠0, else DONE in the same edge.
  - DATA, 4th byte of a word → write mem[words_loaded] (only if words_loaded < DEPTH), then increment words_loaded (saturating at DEPTH).
  - DATA → DONE when the word count reaches N, on the edge that writes the final word.
- load_start while busy: ignored.
- Bytes with rx_valid in IDLE or DONE: discarded.
- Overflow:
  - If N > DEPTH, overflow=1 is set on the edge the 4th header byte is accepted.
  - Loading continues; words with index ≥ DEPTH are consumed but not written.
  - Completion is still after N words.
  - words_loaded reports min(written, DEPTH).
- Read port:
  - Each rising edge, inst_data ← (busy ? 32'h0 : mem[inst_addr]). Latency 1 cycle, every cycle, no handshake.
  - A 32'h0 result reads as a NOP to fetch.
  - inst_addr ≥ DEPTH: returns 32'h0.
  - Read-first: a write and read to the same address on the same edge returns old data (only reachable on the edge leaving DATA; busy forces 0 anyway).
- busy is a registered output, high in HDR and DATA. On the edge entering DONE, busy falls and load_done rises together.
- Reset mid-load: return to IDLE, outputs to reset values. Words already written stay in memory.
- Partial word at load_start: not possible, because load_start is ignored while busy.
- Write port: single, one word per cycle max. A byte arrives at most every cycle, so a word completes at most every 4 cycles.

Test Plan:
- Reset, then load_start, then bytes 00 00 00 02 | 3C 01 00 10 | 00 00 00 0C → load_done=1 and busy=0 on the edge after the last byte, words_loaded=2. Reading addr 0 gives 32'h3C010010 and addr 1 gives 32'h0000000C, each one cycle after the address is applied.
- Header 00 00 00 00 → DONE immediately after the 4th byte, words_loaded=0, memory unchanged.
- DEPTH=4, header 00 00 00 06, then 24 bytes → overflow=1 after the header, words_loaded=4, load_done after the 24th byte, mem[0..3] match the first 4 words.
- During DATA, drive inst_addr=0 with prior content 32'hDEADBEEF → inst_data=0 while busy. After load_done, inst_data shows the newly loaded word.
- Mid-DATA (after 6 bytes) assert rst for 1 cycle → busy=0 and load_done=0. The word at addr 0 from those bytes persists. A fresh load_start restarts the header collection.
- Bytes with gaps (rx_valid low for random 0–5 cycles), plus load_start pulses while busy → identical memory image to the gap-free run, and the extra load_start pulses have no effect.
